// File: rtl/apb2axi_lite_32_64.sv
// APB completer to AXI4-Lite manager bridge: one 32-bit APB transfer becomes
// one 64-bit AXI4-Lite transaction, and the AXI response completes the APB access.
module apb2axi_lite_32_64 #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned APB_DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic                          pwrite_i,
  input  logic [ADDR_WIDTH-1:0]         paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]     pwdata_i,
  input  logic [APB_DATA_WIDTH/8-1:0]   pstrb_i,
  input  logic [2:0]                    pprot_i,
  output logic [APB_DATA_WIDTH-1:0]     prdata_o,
  output logic                          pready_o,
  output logic                          pslverr_o,
  output logic                          aw_valid_o,
  input  logic                          aw_ready_i,
  output logic [ADDR_WIDTH-1:0]         aw_addr_o,
  output logic [2:0]                    aw_prot_o,
  output logic                          w_valid_o,
  input  logic                          w_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]     w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   w_strb_o,
  input  logic                          b_valid_i,
  output logic                          b_ready_o,
  input  logic [1:0]                    b_resp_i,
  output logic                          ar_valid_o,
  input  logic                          ar_ready_i,
  output logic [ADDR_WIDTH-1:0]         ar_addr_o,
  output logic [2:0]                    ar_prot_o,
  input  logic                          r_valid_i,
  output logic                          r_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]     r_data_i,
  input  logic [1:0]                    r_resp_i
);

  localparam int unsigned STRB_W = APB_DATA_WIDTH / 8;

  // Only the 32 -> 64 width pairing is supported.
  if (AXI_DATA_WIDTH != 64) begin : g_bad_axi_width
    $error("apb2axi_lite_32_64: AXI_DATA_WIDTH must be 64");
  end
  if (APB_DATA_WIDTH != 32) begin : g_bad_apb_width
    $error("apb2axi_lite_32_64: APB_DATA_WIDTH must be 32");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_B,
    S_RD,
    S_R,
    S_RESP
  } state_e;

  state_e                    state_q, state_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      capture;
  logic                      resp_err;
  logic                      rdata_load;
  logic [APB_DATA_WIDTH-1:0] rdata_lane;

  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]         strb_q;
  logic [2:0]                prot_q;

  // Only bit 1 of a response distinguishes error from success.
  logic unused_resp_lsb;
  assign unused_resp_lsb = b_resp_i[0] ^ r_resp_i[0];

  assign rdata_lane = addr_q[2] ? r_data_i[AXI_DATA_WIDTH-1 -: APB_DATA_WIDTH]
                                : r_data_i[APB_DATA_WIDTH-1:0];

  // AXI payload comes straight from the capture registers, stable while valid.
  assign aw_addr_o = addr_q;
  assign ar_addr_o = addr_q;
  assign aw_prot_o = prot_q;
  assign ar_prot_o = prot_q;
  assign w_data_o  = {wdata_q, wdata_q};
  assign w_strb_o  = addr_q[2] ? {strb_q, STRB_W'(0)} : {STRB_W'(0), strb_q};

  // State register and AW/W completion flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state logic; AXI inputs only matter in their own wait state.
  always_comb begin
    state_d    = state_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    capture    = 1'b0;
    resp_err   = 1'b0;
    rdata_load = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (psel_i && penable_i) begin
          capture   = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = pwrite_i ? S_WR : S_RD;
        end
      end
      S_WR: begin
        if (aw_valid_o && aw_ready_i) aw_done_d = 1'b1;
        if (w_valid_o && w_ready_i)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)    state_d   = S_B;
      end
      S_B: begin
        if (b_valid_i) begin
          resp_err = b_resp_i[1];
          state_d  = S_RESP;
        end
      end
      S_RD: begin
        if (ar_valid_o && ar_ready_i) state_d = S_R;
      end
      S_R: begin
        if (r_valid_i) begin
          resp_err   = r_resp_i[1];
          rdata_load = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered handshake outputs, decoded from the upcoming state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      aw_valid_o <= 1'b0;
      w_valid_o  <= 1'b0;
      b_ready_o  <= 1'b0;
      ar_valid_o <= 1'b0;
      r_ready_o  <= 1'b0;
      pready_o   <= 1'b0;
      pslverr_o  <= 1'b0;
      prdata_o   <= '0;
    end else begin
      aw_valid_o <= (state_d == S_WR) && !aw_done_d;
      w_valid_o  <= (state_d == S_WR) && !w_done_d;
      b_ready_o  <= (state_d == S_B);
      ar_valid_o <= (state_d == S_RD);
      r_ready_o  <= (state_d == S_R);
      pready_o   <= (state_d == S_RESP);
      pslverr_o  <= resp_err;
      if (rdata_load) prdata_o <= rdata_lane;
    end
  end

  // Capture the APB access phase payload.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
    end else if (capture) begin
      addr_q  <= paddr_i;
      wdata_q <= pwdata_i;
      strb_q  <= pstrb_i;
      prot_q  <= pprot_i;
    end
  end

endmodule

// File: tb/tb_apb2axi_lite_32_64.sv
// Bench for apb2axi_lite_32_64: directed vector table, hand-built latency and
// reset sequences, and random transfers against a word memory model.
module tb_apb2axi_lite_32_64;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic        rst_n, psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pready, pslverr;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] aw_addr, ar_addr;
  logic [2:0]  aw_prot, ar_prot;
  logic [63:0] w_data, r_data;
  logic [7:0]  w_strb;
  logic [1:0]  b_resp, r_resp;

  apb2axi_lite_32_64 dut (
    .clk_i(clk), .rst_ni(rst_n),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pprot_i(pprot),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_prot_o(aw_prot),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr), .ar_prot_o(ar_prot),
    .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_resp_i(r_resp)
  );

  int total = 0;
  int bad   = 0;

  // Slave behaviour knobs, set by the test sequence.
  int unsigned aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic        r_fixed_en = 1'b1;
  logic [63:0] r_fixed_data = 64'h0;

  // Slave-side monitor: handshake counts, last payloads, 64-bit backing store.
  int unsigned aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_vcyc, w_vcyc, aw_unstable;
  logic [31:0] last_aw_addr, last_ar_addr, prev_aw_addr;
  logic [2:0]  last_aw_prot, last_ar_prot;
  logic [63:0] last_w_data;
  logic [7:0]  last_w_strb;
  logic        prev_aw_pend;
  logic [63:0] smem [0:63];

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_vcyc <= 0; w_vcyc <= 0; aw_unstable <= 0; prev_aw_pend <= 1'b0;
      prev_aw_addr <= '0;
      for (int i = 0; i < 64; i++) smem[i] <= '0;
    end else begin
      if (aw_valid) aw_vcyc <= aw_vcyc + 1;
      if (w_valid)  w_vcyc  <= w_vcyc + 1;
      if (aw_valid && prev_aw_pend && aw_addr != prev_aw_addr) aw_unstable <= aw_unstable + 1;
      prev_aw_pend <= aw_valid && !aw_ready;
      prev_aw_addr <= aw_addr;
      if (aw_valid && aw_ready) begin
        aw_cnt <= aw_cnt + 1; last_aw_addr <= aw_addr; last_aw_prot <= aw_prot;
      end
      if (w_valid && w_ready) begin
        w_cnt <= w_cnt + 1; last_w_data <= w_data; last_w_strb <= w_strb;
      end
      if (b_valid && b_ready) begin
        b_cnt <= b_cnt + 1;
        for (int k = 0; k < 8; k++)
          if (last_w_strb[k]) smem[last_aw_addr[8:3]][8*k +: 8] <= last_w_data[8*k +: 8];
      end
      if (ar_valid && ar_ready) begin
        ar_cnt <= ar_cnt + 1; last_ar_addr <= ar_addr; last_ar_prot <= ar_prot;
      end
      if (r_valid && r_ready) r_cnt <= r_cnt + 1;
    end
  end

  // Slave-side driver: readies and responses after the configured delays.
  int unsigned aw_wait, w_wait, b_wait, ar_wait, r_wait;
  always @(negedge clk) begin
    if (!rst_n) begin
      aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
      b_resp = 0; r_resp = 0; r_data = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    end else begin
      if (!aw_valid) begin aw_ready = 0; aw_wait = 0; end
      else if (!aw_ready) begin if (aw_wait >= aw_dly) aw_ready = 1; else aw_wait++; end
      if (!w_valid) begin w_ready = 0; w_wait = 0; end
      else if (!w_ready) begin if (w_wait >= w_dly) w_ready = 1; else w_wait++; end
      if (!ar_valid) begin ar_ready = 0; ar_wait = 0; end
      else if (!ar_ready) begin if (ar_wait >= ar_dly) ar_ready = 1; else ar_wait++; end
      if (!(aw_cnt > b_cnt && w_cnt > b_cnt)) begin b_valid = 0; b_wait = 0; end
      else if (!b_valid) begin
        if (b_wait >= b_dly) begin b_valid = 1; b_resp = b_resp_cfg; end
        else b_wait++;
      end
      if (!(ar_cnt > r_cnt)) begin r_valid = 0; r_wait = 0; end
      else if (!r_valid) begin
        if (r_wait >= r_dly) begin
          r_valid = 1; r_resp = r_resp_cfg;
          r_data  = r_fixed_en ? r_fixed_data : smem[last_ar_addr[8:3]];
        end else r_wait++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One APB transfer; called at a negedge, returns at a negedge with the bus idle.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, input logic [2:0] pr,
                          output logic [31:0] rd, output logic err, output int unsigned cyc);
    int unsigned n;
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st; pprot = pr;
    @(negedge clk);
    penable = 1;
    n = 1;
    while (!pready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("pready timeout", 64'(pready), 64'd1);
    rd = prdata; err = pslverr; cyc = n;
    @(negedge clk);
    psel = 0; penable = 0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [1:0]  resp;
    logic [63:0] rdata;
    logic [31:0] exp_prdata;
    logic        exp_err;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wstrb;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] rmem [0:127];
  logic [31:0] rd;
  logic        err;
  int unsigned cyc;
  int unsigned a0, w0, b0, ar0, r0, av0, wv0, au0;
  logic        wr;
  logic [31:0] addr, wd;
  logic [3:0]  st;

  initial begin
    vecs[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b000, 2'b00, 64'h0,
                32'h0000_0000, 1'b0, 64'hDEADBEEF_DEADBEEF, 8'hF0};
    vecs[1] = '{1'b0, 32'h2000_0000, 32'h0, 4'hF, 3'b010, 2'b00, 64'h11223344_55667788,
                32'h5566_7788, 1'b0, 64'h0, 8'h0};
    vecs[2] = '{1'b0, 32'h2000_0004, 32'h0, 4'hF, 3'b001, 2'b00, 64'h11223344_55667788,
                32'h1122_3344, 1'b0, 64'h0, 8'h0};
    vecs[3] = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'h3, 3'b101, 2'b10, 64'h0,
                32'h1122_3344, 1'b1, 64'hCAFEF00D_CAFEF00D, 8'h03};
    vecs[4] = '{1'b0, 32'h0000_300C, 32'h0, 4'h0, 3'b111, 2'b11, 64'hAAAABBBB_CCCCDDDD,
                32'hAAAA_BBBB, 1'b1, 64'h0, 8'h0};
    vecs[5] = '{1'b1, 32'h0000_0014, 32'h1234_5678, 4'h0, 3'b100, 2'b01, 64'h0,
                32'hAAAA_BBBB, 1'b0, 64'h12345678_12345678, 8'h00};
    vecs[6] = '{1'b0, 32'h0000_0010, 32'h0, 4'hF, 3'b011, 2'b01, 64'h01234567_89ABCDEF,
                32'h89AB_CDEF, 1'b0, 64'h0, 8'h0};
    vecs[7] = '{1'b1, 32'h0000_0008, 32'h0BAD_C0DE, 4'h9, 3'b110, 2'b11, 64'h0,
                32'h89AB_CDEF, 1'b1, 64'h0BADC0DE_0BADC0DE, 8'h09};

    rst_n = 0; psel = 0; penable = 0; pwrite = 0;
    paddr = 0; pwdata = 0; pstrb = 0; pprot = 0;
    repeat (3) @(negedge clk);
    chk("reset pready",  64'(pready),  64'd0);
    chk("reset pslverr", 64'(pslverr), 64'd0);
    chk("reset prdata",  64'(prdata),  64'd0);
    chk("reset valids",  64'({aw_valid, w_valid, ar_valid, b_ready, r_ready}), 64'd0);
    rst_n = 1;
    @(negedge clk);

    // Directed vectors, slave answering with zero delay.
    for (int i = 0; i < 8; i++) begin
      b_resp_cfg = vecs[i].resp; r_resp_cfg = vecs[i].resp; r_fixed_data = vecs[i].rdata;
      a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot, rd, err, cyc);
      chk($sformatf("v%0d pslverr", i), 64'(err), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d prdata", i), 64'(rd), 64'(vecs[i].exp_prdata));
      chk($sformatf("v%0d latency", i), 64'(cyc), 64'd4);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d aw_addr", i), 64'(last_aw_addr), 64'(vecs[i].addr));
        chk($sformatf("v%0d aw_prot", i), 64'(last_aw_prot), 64'(vecs[i].prot));
        chk($sformatf("v%0d w_data", i), last_w_data, vecs[i].exp_wdata);
        chk($sformatf("v%0d w_strb", i), 64'(last_w_strb), 64'(vecs[i].exp_wstrb));
        chk($sformatf("v%0d counts", i),
            64'({8'(aw_cnt - a0), 8'(w_cnt - w0), 8'(b_cnt - b0), 8'(ar_cnt - ar0)}), 64'h0101_0100);
      end else begin
        chk($sformatf("v%0d ar_addr", i), 64'(last_ar_addr), 64'(vecs[i].addr));
        chk($sformatf("v%0d ar_prot", i), 64'(last_ar_prot), 64'(vecs[i].prot));
        chk($sformatf("v%0d counts", i),
            64'({8'(aw_cnt - a0), 8'(ar_cnt - ar0), 8'(r_cnt - r0)}), 64'h00_0101);
      end
    end

    // W accepted at once, AW held off 5 cycles.
    b_resp_cfg = 2'b00; aw_dly = 5; w_dly = 0;
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; av0 = aw_vcyc; wv0 = w_vcyc; au0 = aw_unstable;
    apb_xfer(1'b1, 32'h0000_0040, 32'h5A5A_0001, 4'hF, 3'b000, rd, err, cyc);
    chk("awslow latency", 64'(cyc), 64'd9);
    chk("awslow aw_valid cycles", 64'(aw_vcyc - av0), 64'd6);
    chk("awslow w_valid cycles", 64'(w_vcyc - wv0), 64'd1);
    chk("awslow aw_addr stable", 64'(aw_unstable - au0), 64'd0);
    chk("awslow counts", 64'({8'(aw_cnt - a0), 8'(w_cnt - w0), 8'(b_cnt - b0)}), 64'h01_0101);
    chk("awslow pslverr", 64'(err), 64'd0);

    // AW at once, W held 3 cycles, B held 2 cycles.
    aw_dly = 0; w_dly = 3; b_dly = 2;
    av0 = aw_vcyc; wv0 = w_vcyc;
    apb_xfer(1'b1, 32'h0000_0044, 32'h5A5A_0002, 4'hF, 3'b000, rd, err, cyc);
    chk("wslow latency", 64'(cyc), 64'd9);
    chk("wslow aw_valid cycles", 64'(aw_vcyc - av0), 64'd1);
    chk("wslow w_valid cycles", 64'(w_vcyc - wv0), 64'd4);

    // Read with AR and R delayed, error response still returns the lane.
    w_dly = 0; b_dly = 0; ar_dly = 3; r_dly = 4;
    r_resp_cfg = 2'b10; r_fixed_data = 64'hFEEDFACE_00C0FFEE;
    apb_xfer(1'b0, 32'h0000_0004, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    chk("rdslow latency", 64'(cyc), 64'd11);
    chk("rdslow prdata", 64'(rd), 64'hFEED_FACE);
    chk("rdslow pslverr", 64'(err), 64'd1);
    ar_dly = 0; r_dly = 0; r_resp_cfg = 2'b00;

    // Reset pulse while waiting in B.
    b_dly = 6;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h0000_0080; pwdata = 32'h7777_8888;
    pstrb = 4'hF; pprot = 3'b000;
    @(negedge clk);
    penable = 1;
    for (int n = 0; n < 20 && !b_ready; n++) @(negedge clk);
    chk("rstB reached B", 64'(b_ready), 64'd1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; psel = 0; penable = 0; b_dly = 0;
    chk("rstB handshake outs", 64'({aw_valid, w_valid, ar_valid, b_ready, r_ready}), 64'd0);
    chk("rstB pready/pslverr", 64'({pready, pslverr}), 64'd0);
    chk("rstB prdata", 64'(prdata), 64'd0);
    chk("rstB aw_addr", 64'(aw_addr), 64'd0);
    @(negedge clk);
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    apb_xfer(1'b1, 32'h0000_0088, 32'h1357_9BDF, 4'hF, 3'b000, rd, err, cyc);
    chk("rstB next latency", 64'(cyc), 64'd4);
    chk("rstB next pslverr", 64'(err), 64'd0);
    chk("rstB next w_data", last_w_data, 64'h13579BDF_13579BDF);
    chk("rstB next counts", 64'({8'(aw_cnt - a0), 8'(w_cnt - w0), 8'(b_cnt - b0)}), 64'h01_0101);

    // Random transfers against a 32-bit word model; slave memory cleared by reset.
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    r_fixed_en = 0;
    for (int i = 0; i < 128; i++) rmem[i] = '0;
    @(negedge clk);
    for (int t = 0; t < 1000; t++) begin
      aw_dly = $urandom_range(0, 7); w_dly = $urandom_range(0, 7); b_dly = $urandom_range(0, 7);
      ar_dly = $urandom_range(0, 7); r_dly = $urandom_range(0, 7);
      b_resp_cfg = {1'b0, 1'($urandom_range(0, 1))};
      r_resp_cfg = {1'b0, 1'($urandom_range(0, 1))};
      wr   = 1'($urandom_range(0, 1));
      addr = {23'h0, 7'($urandom_range(0, 127)), 2'b00};
      wd   = $urandom;
      st   = 4'($urandom_range(0, 15));
      a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
      apb_xfer(wr, addr, wd, st, 3'b000, rd, err, cyc);
      chk($sformatf("rnd%0d pslverr", t), 64'(err), 64'd0);
      if (wr) begin
        for (int k = 0; k < 4; k++) if (st[k]) rmem[addr[8:2]][8*k +: 8] = wd[8*k +: 8];
        chk($sformatf("rnd%0d wr counts", t),
            64'({8'(aw_cnt - a0), 8'(w_cnt - w0), 8'(b_cnt - b0), 8'(ar_cnt - ar0), 8'(r_cnt - r0)}),
            64'h01_0101_0000);
      end else begin
        chk($sformatf("rnd%0d rd data @%h", t, addr), 64'(rd), 64'(rmem[addr[8:2]]));
        chk($sformatf("rnd%0d rd counts", t),
            64'({8'(aw_cnt - a0), 8'(w_cnt - w0), 8'(b_cnt - b0), 8'(ar_cnt - ar0), 8'(r_cnt - r0)}),
            64'h00_0000_0101);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
